// File: rtl/auth_engine.sv
// Account/PIN authenticator: a provisioned table searched one entry per cycle,
// with per-account failed-attempt counting, lockout and admin unlock.
module auth_engine #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 4,
  parameter int PIN_W        = 16,
  parameter int IDX_W        = 4,
  parameter int MAX_TRIES    = 3,
  parameter int TRY_W        = 2,
  parameter logic [PIN_W-1:0] ADMIN_PIN = 16'd9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ACC_W-1:0] req_acc,
  input  logic [PIN_W-1:0] req_pin,
  input  logic [PIN_W-1:0] req_new_pin,
  input  logic             db_wr_en,
  input  logic [IDX_W-1:0] db_wr_idx,
  input  logic [ACC_W-1:0] db_wr_acc,
  input  logic [PIN_W-1:0] db_wr_pin,
  output logic             rsp_valid,
  output logic [2:0]       rsp_status,
  output logic [IDX_W-1:0] rsp_index,
  output logic [TRY_W-1:0] rsp_tries_left
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_AUTH   = 2'b00;
  localparam logic [1:0] OP_CHANGE = 2'b01;
  localparam logic [1:0] OP_UNLOCK = 2'b10;
  localparam logic [1:0] OP_BAD    = 2'b11;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_NOT_FOUND = 3'd1;
  localparam logic [2:0] ST_BAD_PIN   = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_SAME_PIN  = 3'd4;
  localparam logic [2:0] ST_BAD_OP    = 3'd5;

  localparam logic [TRY_W-1:0] MAX_T    = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);
  localparam logic [IDX_W:0]   NUM_ENT  = (IDX_W + 1)'(NUM_ACCOUNTS);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, hit_q, hit_d;
  logic              found_q, found_d;
  logic [1:0]        op_q, op_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PIN_W-1:0]  pin_q, pin_d, new_pin_q, new_pin_d;

  logic [ACC_W-1:0]  tbl_acc_q [NUM_ACCOUNTS];
  logic [ACC_W-1:0]  tbl_acc_d [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  tbl_pin_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  tbl_pin_d [NUM_ACCOUNTS];
  logic [TRY_W-1:0]  fail_q [NUM_ACCOUNTS];
  logic [TRY_W-1:0]  fail_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] valid_q, valid_d, lock_q, lock_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [2:0]        rsp_status_q, rsp_status_d;
  logic [IDX_W-1:0]  rsp_index_q, rsp_index_d;
  logic [TRY_W-1:0]  rsp_tries_q, rsp_tries_d;

  logic [PIN_W-1:0]  e_pin;
  logic [TRY_W-1:0]  e_cnt, e_cnt_inc;
  logic              e_locked;

  assign req_ready      = (state_q == S_IDLE) & ~db_wr_en;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_status     = rsp_status_q;
  assign rsp_index      = rsp_index_q;
  assign rsp_tries_left = rsp_tries_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    found_d      = found_q;
    op_d         = op_q;
    acc_d        = acc_q;
    pin_d        = pin_q;
    new_pin_d    = new_pin_q;
    tbl_acc_d    = tbl_acc_q;
    tbl_pin_d    = tbl_pin_q;
    fail_d       = fail_q;
    valid_d      = valid_q;
    lock_d       = lock_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_index_d  = rsp_index_q;
    rsp_tries_d  = rsp_tries_q;
    e_pin        = tbl_pin_q[hit_q];
    e_cnt        = fail_q[hit_q];
    e_locked     = lock_q[hit_q];
    e_cnt_inc    = (e_cnt == MAX_T) ? e_cnt : e_cnt + {{(TRY_W-1){1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (db_wr_en) begin
          if ({1'b0, db_wr_idx} < NUM_ENT) begin
            tbl_acc_d[db_wr_idx] = db_wr_acc;
            tbl_pin_d[db_wr_idx] = db_wr_pin;
            valid_d[db_wr_idx]   = 1'b1;
            lock_d[db_wr_idx]    = 1'b0;
            fail_d[db_wr_idx]    = '0;
          end else begin
            valid_d = valid_q;
          end
        end else if (req_valid) begin
          op_d      = req_op;
          acc_d     = req_acc;
          pin_d     = req_pin;
          new_pin_d = req_new_pin;
          idx_d     = '0;
          hit_d     = '0;
          found_d   = 1'b0;
          // Reserved op skips the search but still spends one cycle in CHECK.
          state_d   = (req_op == OP_BAD) ? S_CHECK : S_SEARCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (valid_q[idx_q] && (tbl_acc_q[idx_q] == acc_q)) begin
          found_d = 1'b1;
          hit_d   = idx_q;
          state_d = S_CHECK;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_CHECK;
        end else begin
          idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      S_CHECK: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_index_d = '0;
        rsp_tries_d = '0;
        if (op_q == OP_BAD) begin
          rsp_status_d = ST_BAD_OP;
        end else if (!found_q) begin
          rsp_status_d = ST_NOT_FOUND;
        end else begin
          rsp_index_d = hit_q;
          if (op_q == OP_UNLOCK) begin
            if (pin_q == ADMIN_PIN) begin
              lock_d[hit_q] = 1'b0;
              fail_d[hit_q] = '0;
              rsp_status_d  = ST_OK;
              rsp_tries_d   = MAX_T;
            end else begin
              rsp_status_d = ST_BAD_PIN;
              rsp_tries_d  = MAX_T - e_cnt;
            end
          end else if (e_locked) begin
            rsp_status_d = ST_LOCKED;
            rsp_tries_d  = MAX_T - e_cnt;
          end else if (pin_q == e_pin) begin
            fail_d[hit_q] = '0;
            rsp_tries_d   = MAX_T;
            if ((op_q == OP_CHANGE) && (new_pin_q == e_pin)) begin
              rsp_status_d = ST_SAME_PIN;
            end else begin
              tbl_pin_d[hit_q] = (op_q == OP_CHANGE) ? new_pin_q : e_pin;
              rsp_status_d     = ST_OK;
            end
          end else begin
            fail_d[hit_q] = e_cnt_inc;
            lock_d[hit_q] = (e_cnt_inc == MAX_T);
            rsp_status_d  = ST_BAD_PIN;
            rsp_tries_d   = MAX_T - e_cnt_inc;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hit_q        <= '0;
      found_q      <= 1'b0;
      op_q         <= 2'b00;
      acc_q        <= '0;
      pin_q        <= '0;
      new_pin_q    <= '0;
      tbl_acc_q    <= '{default: '0};
      tbl_pin_q    <= '{default: '0};
      fail_q       <= '{default: '0};
      valid_q      <= '0;
      lock_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 3'd0;
      rsp_index_q  <= '0;
      rsp_tries_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      found_q      <= found_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      pin_q        <= pin_d;
      new_pin_q    <= new_pin_d;
      tbl_acc_q    <= tbl_acc_d;
      tbl_pin_q    <= tbl_pin_d;
      fail_q       <= fail_d;
      valid_q      <= valid_d;
      lock_q       <= lock_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_index_q  <= rsp_index_d;
      rsp_tries_q  <= rsp_tries_d;
    end
  end

endmodule

// File: tb/tb_auth_engine.sv
// Self-checking bench for auth_engine: directed scenarios plus randomized traffic
// checked against a table-level reference model of the authentication rules.
module tb_auth_engine;
  localparam int N    = 10;
  localparam int MAXT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_acc;
  logic [15:0] req_pin, req_new_pin;
  logic        db_wr_en;
  logic [3:0]  db_wr_idx, db_wr_acc;
  logic [15:0] db_wr_pin;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [3:0]  rsp_index;
  logic [1:0]  rsp_tries_left;

  int tests = 0;
  int fails = 0;

  bit m_valid [N];
  bit m_lock  [N];
  int m_acc   [N];
  int m_pin   [N];
  int m_fail  [N];

  auth_engine dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acc(req_acc), .req_pin(req_pin), .req_new_pin(req_new_pin),
    .db_wr_en(db_wr_en), .db_wr_idx(db_wr_idx), .db_wr_acc(db_wr_acc),
    .db_wr_pin(db_wr_pin),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_index(rsp_index),
    .rsp_tries_left(rsp_tries_left)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_lock[i] = 1'b0; m_fail[i] = 0; m_acc[i] = 0; m_pin[i] = 0;
    end
  endtask

  // Expected latency counts clock edges after the accepting edge.
  task automatic model_req(input int op, input int acc, input int pin, input int npin,
                           output int lat, output int st, output int idx, output int tl);
    int k;
    k = -1; idx = 0; tl = 0;
    if (op == 3) begin
      lat = 1; st = 5; return;
    end
    for (int i = 0; i < N; i++) begin
      if (k < 0 && m_valid[i] && m_acc[i] == acc) k = i;
    end
    if (k < 0) begin
      lat = N + 1; st = 1; return;
    end
    lat = k + 2; idx = k;
    if (op == 2) begin
      if (pin == 9999) begin m_lock[k] = 1'b0; m_fail[k] = 0; st = 0; end
      else st = 2;
    end else if (m_lock[k]) begin
      st = 3;
    end else if (pin == m_pin[k]) begin
      m_fail[k] = 0;
      if (op == 1 && npin == m_pin[k]) st = 4;
      else begin
        if (op == 1) m_pin[k] = npin;
        st = 0;
      end
    end else begin
      m_fail[k] = (m_fail[k] + 1 > MAXT) ? MAXT : m_fail[k] + 1;
      if (m_fail[k] == MAXT) m_lock[k] = 1'b1;
      st = 2;
    end
    tl = MAXT - m_fail[k];
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL ready_timeout: req_ready stayed 0, required 1");
    end
  endtask

  task automatic provision(input int idx, input int acc, input int pin);
    wait_ready();
    db_wr_en = 1'b1; db_wr_idx = 4'(idx); db_wr_acc = 4'(acc); db_wr_pin = 16'(pin);
    @(posedge clk); #1;
    db_wr_en = 1'b0;
    if (idx < N) begin
      m_valid[idx] = 1'b1; m_acc[idx] = acc; m_pin[idx] = pin;
      m_lock[idx] = 1'b0; m_fail[idx] = 0;
    end
  endtask

  task automatic send(input int op, input int acc, input int pin, input int npin,
                      output int lat, output int st, output int idx, output int tl);
    wait_ready();
    req_valid = 1'b1; req_op = 2'(op); req_acc = 4'(acc);
    req_pin = 16'(pin); req_new_pin = 16'(npin);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; st = 7; idx = 15; tl = 3;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) begin
        lat = n; st = int'(rsp_status); idx = int'(rsp_index); tl = int'(rsp_tries_left);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; db_wr_en = 1'b0;
    req_op = 2'b00; req_acc = 4'd0; req_pin = 16'd0; req_new_pin = 16'd0;
    db_wr_idx = 4'd0; db_wr_acc = 4'd0; db_wr_pin = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    tests++;
    if ({rsp_valid, rsp_status, rsp_index, rsp_tries_left, req_ready} !== {1'b0, 3'd0, 4'd0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got v=%b st=%0d idx=%0d tl=%0d rdy=%b, expected 0 0 0 0 1",
               rsp_valid, rsp_status, rsp_index, rsp_tries_left, req_ready);
    end
  endtask

  // Runs a list of requests {op,acc,pin,new_pin} against DUT and model.
  task automatic test_list(input string name, input int ops[$], input int accs[$],
                           input int pins[$], input int npins[$]);
    int gl, gs, gi, gt, el, es, ei, et;
    for (int i = 0; i < ops.size(); i++) begin
      send(ops[i], accs[i], pins[i], npins[i], gl, gs, gi, gt);
      model_req(ops[i], accs[i], pins[i], npins[i], el, es, ei, et);
      tests++;
      if ({gl, gs, gi, gt} !== {el, es, ei, et}) begin
        fails++;
        $display("FAIL %s[%0d]: got lat=%0d st=%0d idx=%0d tl=%0d, expected lat=%0d st=%0d idx=%0d tl=%0d",
                 name, i, gl, gs, gi, gt, el, es, ei, et);
      end
    end
  endtask

  task automatic test_auth();
    provision(2, 5, 1234);
    test_list("auth", '{0, 0}, '{5, 9}, '{1234, 1234}, '{0, 0});
  endtask

  task automatic test_lockout();
    test_list("lockout", '{0, 0, 0, 0}, '{5, 5, 5, 5}, '{1111, 1111, 1111, 1234}, '{0, 0, 0, 0});
  endtask

  task automatic test_unlock();
    test_list("unlock", '{2, 2, 0}, '{5, 5, 5}, '{0, 9999, 1234}, '{0, 0, 0});
  endtask

  task automatic test_change_pin();
    test_list("change_pin", '{1, 1, 0, 0}, '{5, 5, 5, 5}, '{1234, 1234, 1234, 4321},
              '{1234, 4321, 0, 0});
  endtask

  task automatic test_bad_op();
    test_list("bad_op", '{3}, '{5}, '{4321}, '{0});
  endtask

  task automatic test_wr_priority();
    bit seen;
    wait_ready();
    db_wr_en = 1'b1; db_wr_idx = 4'd4; db_wr_acc = 4'd7; db_wr_pin = 16'd777;
    req_valid = 1'b1; req_op = 2'b00; req_acc = 4'd5; req_pin = 16'd4321;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL wr_priority_ready: got %b, expected 0", req_ready);
    end
    @(posedge clk); #1;
    db_wr_en = 1'b0; req_valid = 1'b0;
    m_valid[4] = 1'b1; m_acc[4] = 7; m_pin[4] = 777; m_lock[4] = 1'b0; m_fail[4] = 0;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL wr_priority_no_rsp: got rsp_valid=1, expected 0");
    end
    test_list("wr_priority", '{0}, '{7}, '{777}, '{0});
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    wait_ready();
    req_valid = 1'b1; req_op = 2'b00; req_acc = 4'd9; req_pin = 16'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_ready: got %b, expected 1", req_ready);
    end
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL mid_reset_no_rsp: got rsp_valid=1, expected 0");
    end
    test_list("after_reset", '{0}, '{5}, '{4321}, '{0});
  endtask

  task automatic test_random();
    int pool[5] = '{1234, 1111, 4321, 9999, 0};
    int gl, gs, gi, gt, el, es, ei, et;
    int op, acc, pin, npin;
    for (int i = 0; i < 8; i++)
      provision(int'($urandom_range(0, 11)), int'($urandom_range(0, 7)), pool[$urandom_range(0, 4)]);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0)
        provision(int'($urandom_range(0, 11)), int'($urandom_range(0, 7)), pool[$urandom_range(0, 4)]);
      op   = int'($urandom_range(0, 3));
      acc  = int'($urandom_range(0, 8));
      pin  = pool[$urandom_range(0, 4)];
      npin = pool[$urandom_range(0, 4)];
      send(op, acc, pin, npin, gl, gs, gi, gt);
      model_req(op, acc, pin, npin, el, es, ei, et);
      tests++;
      if ({gl, gs, gi, gt} !== {el, es, ei, et}) begin
        fails++;
        $display("FAIL random[%0d] op=%0d acc=%0d: got lat=%0d st=%0d idx=%0d tl=%0d, expected lat=%0d st=%0d idx=%0d tl=%0d",
                 i, op, acc, gl, gs, gi, gt, el, es, ei, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_auth();
    test_lockout();
    test_unlock();
    test_change_pin();
    test_bad_op();
    test_wr_priority();
    test_reset_mid_search();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
